// File: rtl/logip_pkg.sv
// -----------------------------------------------------------------------------
// logip_pkg
// Shared types and constants for the logic analyzer transmit backend.
//   tx_state_t        : serializer FSM states (PARITY only used when the
//                       LOGIP_TX_PARITY_EN macro is defined)
//   TX_BYTES_PER_WORD : bytes sent per 32-bit result word
//   TX_DATA_BITS      : data bits per UART frame
// -----------------------------------------------------------------------------
package logip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int TX_BYTES_PER_WORD = 4;
  localparam int TX_DATA_BITS      = 8;

endpackage

// File: rtl/word_uart_tx_baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Bit-time counter for the UART serializer. Counts 0..CLK_PER_BIT-1 and wraps.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_in  : synchronous active-low reset
//   clr_i   : restart the bit time (counter to 0 at the next edge)
//   tick_o  : high during the last cycle of each bit time
// -----------------------------------------------------------------------------
module baud_gen #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/word_uart_tx.sv
// -----------------------------------------------------------------------------
// word_uart_tx
// Serializes 32-bit result words as four UART bytes, least significant byte
// first, with no idle gap between the bytes of one word.
// Ports:
//   clk_i    : system clock, rising edge
//   rst_in   : synchronous active-low reset
//   tx_stb_i : word strobe, qualified by tx_rdy_o
//   tx_i     : 32-bit word, latched on acceptance
//   tx_rdy_o : ready for a new word (registered)
//   tx_o     : UART line, idle high (registered)
// Optional feature: define LOGIP_TX_PARITY_EN for 8E1 frames (even parity
// bit between data and stop); otherwise frames are 8N1.
// -----------------------------------------------------------------------------
module word_uart_tx
  import logip_pkg::*;
#(
  parameter int CLK_PER_BIT = 100
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        tx_stb_i,
  input  logic [31:0] tx_i,
  output logic        tx_rdy_o,
  output logic        tx_o
);

  localparam logic [2:0] LAST_BIT  = 3'(TX_DATA_BITS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(TX_BYTES_PER_WORD - 1);

  tx_state_t   state_q, state_d;
  logic [31:0] sreg_q, sreg_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic        baud_clr;
  logic        tick;
`ifdef LOGIP_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  baud_gen #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  // The line and ready flags are computed one cycle ahead so both outputs
  // come straight from flops and change on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    tx_d     = tx_q;
    rdy_d    = rdy_q;
    baud_clr = 1'b0;
`ifdef LOGIP_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
        if (tx_stb_i && rdy_q) begin
          state_d  = START;
          sreg_d   = tx_i;
          bit_d    = '0;
          byte_d   = '0;
          tx_d     = 1'b0;
          rdy_d    = 1'b0;
          baud_clr = 1'b1;  // first start bit gets a full bit time
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sreg_q[0];
`ifdef LOGIP_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      DATA: begin
        if (tick) begin
          // Bit 0 has just been sent; shifting right exposes the next one.
          // After eight shifts the next byte sits in the low bits.
          sreg_d = {1'b0, sreg_q[31:1]};
`ifdef LOGIP_TX_PARITY_EN
          par_d  = par_q ^ sreg_q[0];
`endif
          if (bit_q == LAST_BIT) begin
`ifdef LOGIP_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q ^ sreg_q[0];
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sreg_q[1];
          end
        end
      end
`ifdef LOGIP_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            byte_d  = '0;
            tx_d    = 1'b1;
            rdy_d   = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 2'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
`ifdef LOGIP_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
`ifdef LOGIP_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_o     = tx_q;
  assign tx_rdy_o = rdy_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_word_uart_tx
// Scoreboard bench for word_uart_tx with CLK_PER_BIT = 4. Stimulus pushes the
// hand-written expected bytes; a line monitor decodes UART frames and pops.
// Honours LOGIP_TX_PARITY_EN for the 8E1 frame format.
// -----------------------------------------------------------------------------
module tb_word_uart_tx;

  localparam int C = 4;
`ifdef LOGIP_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FL = F * C;
  localparam int WORD_CYC = 4 * F * C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] din = '0;
  logic        rdy;
  logic        txl;

  int n_cmp  = 0;
  int n_fail = 0;
  int frames = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  word_uart_tx #(
    .CLK_PER_BIT(C)
  ) dut (
    .clk_i   (clk),
    .rst_in  (rst_n),
    .tx_stb_i(stb),
    .tx_i    (din),
    .tx_rdy_o(rdy),
    .tx_o    (txl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  // Line monitor: samples on the falling edge, collects one full frame from
  // the start bit, then checks bit widths, stop/parity and the byte value.
  initial begin
    logic smp[FL];
    int   n;
    bit   busy;
    logic shape_ok;
    logic [7:0] got;
    logic [7:0] e;
    busy = 1'b0;
    n    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        n    = 0;
      end else if (!busy) begin
        if (txl === 1'b0) begin
          busy   = 1'b1;
          smp[0] = txl;
          n      = 1;
        end
      end else begin
        smp[n] = txl;
        n++;
        if (n == FL) begin
          busy     = 1'b0;
          shape_ok = 1'b1;
          for (int b = 0; b < F; b++)
            for (int s = 1; s < C; s++)
              if (smp[b*C+s] !== smp[b*C]) shape_ok = 1'b0;
          for (int i = 0; i < 8; i++) got[i] = smp[(1+i)*C];
          frames++;
          $display("frame %0d: byte 0x%02h", frames, got);
          chk("bit_width", 32'(shape_ok), 32'd1);
          chk("stop_bit", 32'(smp[(F-1)*C]), 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%02h required none", got);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(got), 32'(e));
`ifdef LOGIP_TX_PARITY_EN
            chk("parity", 32'(smp[9*C]), 32'(^e));
`endif
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (rdy !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got rdy=%b required 1", rdy);
    end
  endtask

  // Strobe one word; optionally measure how long tx_rdy_o stays low.
  task automatic send(input logic [31:0] w, input int exp_low);
    int cnt;
    wait_ready();
    stb = 1'b1;
    din = w;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    chk("rdy_after_accept", 32'(rdy), 32'd0);
    chk("start_after_accept", 32'(txl), 32'd0);
    if (exp_low > 0) begin
      cnt = 1;
      while (cnt < 2000) begin
        @(negedge clk);
        if (rdy === 1'b1) break;
        cnt++;
      end
      chk("rdy_low_cycles", 32'(cnt), 32'(exp_low));
    end
  endtask

  task automatic drain();
    wait_ready();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    // Reset held with a toggling strobe: line idle and ready throughout.
    din = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stb = ~stb;
      chk("reset_tx", 32'(txl), 32'd1);
      chk("reset_rdy", 32'(rdy), 32'd1);
    end
    @(negedge clk);
    stb   = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_frame_after_reset", 32'(frames), 32'd0);
    chk("idle_line", 32'(txl), 32'd1);

    // Single word.
    expect4(8'h11, 8'h22, 8'h33, 8'h44);
    send(32'h4433_2211, WORD_CYC);
    drain();

    // Back-to-back: second word strobed in the first ready cycle.
    expect4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    expect4(8'h67, 8'h45, 8'h23, 8'h01);
    send(32'hDEAD_BEEF, WORD_CYC);
    chk("gap_line_high", 32'(txl), 32'd1);
    send(32'h0123_4567, WORD_CYC);
    drain();

    // Busy strobe is dropped.
    expect4(8'h00, 8'h00, 8'h00, 8'h00);
    send(32'h0000_0000, 0);
    repeat (20) @(negedge clk);
    stb = 1'b1;
    din = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    stb = 1'b0;
    chk("busy_still_low", 32'(rdy), 32'd0);
    drain();
    f0 = frames;
    repeat (60) @(negedge clk);
    chk("dropped_word_not_sent", 32'(frames), 32'(f0));

    // Reset during byte 2, data bit 3.
    expect4(8'h78, 8'h56, 8'h34, 8'h12);
    send(32'h1234_5678, 0);
    repeat (97) @(negedge clk);
    chk("busy_before_reset", 32'(rdy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_tx", 32'(txl), 32'd1);
    chk("midreset_rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    expect4(8'hA5, 8'h00, 8'h00, 8'h00);
    send(32'h0000_00A5, WORD_CYC);
    drain();

`ifdef LOGIP_TX_PARITY_EN
    expect4(8'h07, 8'h03, 8'h00, 8'h00);
    send(32'h0000_0307, 176);
    drain();
`endif

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
